// File: rtl/usb_rx_bit_decoder_pkg.sv
// Shared constants and helpers for the USB full-speed receive bit decoder.
package usb_rx_pkg;

    localparam int unsigned CLKS_PER_BIT = 8;
    localparam int unsigned SAMPLE_PT    = 3;
    localparam int unsigned MAX_ONES     = 6;

    // Full-speed idle (J) level on D+.
    localparam logic        LINE_J       = 1'b1;

    localparam int unsigned PHASE_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned ONES_W       = 3;
    localparam int unsigned BIT_CNT_W    = 3;

    // Single-ended zero: both data lines low.
    function automatic logic is_se0(input logic dp, input logic dm);
        return (!dp) && (!dm);
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder_if.sv
// Line inputs and decoded-bit outputs between the line front end,
// the bit decoder and the receive shift register / RX control unit.
interface usb_rx_bit_decoder_if;

    logic d_plus_sync;
    logic d_minus_sync;
    logic rcving;
    logic shift_enable;
    logic d_sent;
    logic stuff_bit;
    logic byte_received;
    logic eop;
    logic stuff_error;

    modport master (
        output d_plus_sync,
        output d_minus_sync,
        output rcving,
        input  shift_enable,
        input  d_sent,
        input  stuff_bit,
        input  byte_received,
        input  eop,
        input  stuff_error
    );

    modport slave (
        input  d_plus_sync,
        input  d_minus_sync,
        input  rcving,
        output shift_enable,
        output d_sent,
        output stuff_bit,
        output byte_received,
        output eop,
        output stuff_error
    );

endinterface

// File: rtl/usb_rx_bit_decoder_phase_timer.sv
// Bit-phase counter with edge resync; strobes once per bit time at the
// configured sample point.
module usb_rx_phase_timer #(
    parameter int unsigned CLKS_PER_BIT = usb_rx_pkg::CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PT    = usb_rx_pkg::SAMPLE_PT
) (
    input  logic clk,
    input  logic rst,
    input  logic rcving_i,
    input  logic line_i,
    output logic sample_o
);
    import usb_rx_pkg::*;

    localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          line_q,  line_d;

    // Next phase: restart at 1 after a line transition, else wrap-count.
    always_comb begin
        phase_d = '0;
        line_d  = LINE_J;
        if (rcving_i) begin
            line_d = line_i;
            if (line_i != line_q) begin
                phase_d = PW'(1);
            end else if (phase_q == PW'(CLKS_PER_BIT - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Phase and delayed-line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            line_q  <= LINE_J;
        end else begin
            phase_q <= phase_d;
            line_q  <= line_d;
        end
    end

    // Sampling uses the current phase, so an edge in the sample cycle
    // still samples first and only realigns from the next cycle.
    assign sample_o = rcving_i && (phase_q == PW'(SAMPLE_PT));

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: clock recovery, NRZI decode, bit destuffing,
// SE0/EOP detection and byte-boundary signalling for the RX shift register.
module usb_rx_bit_decoder #(
    parameter int unsigned CLKS_PER_BIT = usb_rx_pkg::CLKS_PER_BIT,
    parameter int unsigned SAMPLE_PT    = usb_rx_pkg::SAMPLE_PT,
    parameter int unsigned MAX_ONES     = usb_rx_pkg::MAX_ONES
) (
    input  logic                   clk,
    input  logic                   rst,
    usb_rx_bit_decoder_if.slave    bus
);
    import usb_rx_pkg::*;

    logic                 sample;

    logic                 prev_q,          prev_d;
    logic [ONES_W-1:0]    ones_q,          ones_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,       bit_cnt_d;
    logic                 shift_enable_q,  shift_enable_d;
    logic                 d_sent_q,        d_sent_d;
    logic                 stuff_bit_q,     stuff_bit_d;
    logic                 byte_received_q, byte_received_d;
    logic                 eop_q,           eop_d;
    logic                 stuff_error_q,   stuff_error_d;
    logic                 dec;

    usb_rx_phase_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PT    (SAMPLE_PT)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .rcving_i (bus.rcving),
        .line_i   (bus.d_plus_sync),
        .sample_o (sample)
    );

    // NRZI: no change since the previous bit decodes as 1.
    assign dec = (bus.d_plus_sync == prev_q);

    // Per-sample decode, destuff and byte counting.
    always_comb begin
        prev_d          = prev_q;
        ones_d          = ones_q;
        bit_cnt_d       = bit_cnt_q;
        shift_enable_d  = 1'b0;
        d_sent_d        = d_sent_q;
        stuff_bit_d     = 1'b0;
        eop_d           = 1'b0;
        stuff_error_d   = 1'b0;
        // The bit that wrapped bit_cnt to 0 was shifted last cycle; a stuff
        // bit never advances bit_cnt, so it cannot delay this.
        byte_received_d = shift_enable_q && !stuff_bit_q && (bit_cnt_q == '0);

        if (!bus.rcving) begin
            prev_d          = LINE_J;
            ones_d          = '0;
            bit_cnt_d       = '0;
            d_sent_d        = 1'b0;
            byte_received_d = 1'b0;
        end else if (sample) begin
            if (is_se0(bus.d_plus_sync, bus.d_minus_sync)) begin
                eop_d     = 1'b1;
                ones_d    = '0;
                bit_cnt_d = '0;
            end else begin
                shift_enable_d = 1'b1;
                d_sent_d       = dec;
                prev_d         = bus.d_plus_sync;
                if (ones_q == ONES_W'(MAX_ONES)) begin
                    stuff_bit_d   = 1'b1;
                    stuff_error_d = dec;
                    ones_d        = '0;
                end else begin
                    ones_d    = dec ? (ones_q + 1'b1) : '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q          <= LINE_J;
            ones_q          <= '0;
            bit_cnt_q       <= '0;
            shift_enable_q  <= 1'b0;
            d_sent_q        <= 1'b0;
            stuff_bit_q     <= 1'b0;
            byte_received_q <= 1'b0;
            eop_q           <= 1'b0;
            stuff_error_q   <= 1'b0;
        end else begin
            prev_q          <= prev_d;
            ones_q          <= ones_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_enable_q  <= shift_enable_d;
            d_sent_q        <= d_sent_d;
            stuff_bit_q     <= stuff_bit_d;
            byte_received_q <= byte_received_d;
            eop_q           <= eop_d;
            stuff_error_q   <= stuff_error_d;
        end
    end

    assign bus.shift_enable  = shift_enable_q;
    assign bus.d_sent        = d_sent_q;
    assign bus.stuff_bit     = stuff_bit_q;
    assign bus.byte_received = byte_received_q;
    assign bus.eop           = eop_q;
    assign bus.stuff_error   = stuff_error_q;

endmodule
